// File: rtl/datapath_axil_pkg.sv
// Shared constants, channel state encodings and the byte-strobe merge helper
// for the Datapath S00_AXI register file.
package datapath_axil_pkg;

    localparam int ADDR_LSB = 2;
    localparam int NUM_REGS = 4;
    localparam int IDX_W    = $clog2(NUM_REGS);

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_t;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/datapath_axil_regs.sv
// AXI4-Lite slave holding four 32-bit control registers for the datapath.
// Write and read channels are independent FSMs; READYs decode from state only.
module datapath_axil_regs
    import datapath_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                                     ACLK,
    input  logic                                     ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
    input  logic [2:0]                               S_AXI_AWPROT,
    input  logic                                     S_AXI_AWVALID,
    output logic                                     S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
    input  logic                                     S_AXI_WVALID,
    output logic                                     S_AXI_WREADY,
    output logic [1:0]                               S_AXI_BRESP,
    output logic                                     S_AXI_BVALID,
    input  logic                                     S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
    input  logic [2:0]                               S_AXI_ARPROT,
    input  logic                                     S_AXI_ARVALID,
    output logic                                     S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
    output logic [1:0]                               S_AXI_RRESP,
    output logic                                     S_AXI_RVALID,
    input  logic                                     S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   reg_q,
    output logic [NUM_REGS-1:0]                      reg_wr
);

    wstate_t w_state;
    rstate_t r_state;

    logic [IDX_W-1:0]                          aw_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0]             wdata_q;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]           wstrb_q;
    logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] regs;

    logic aw_hs, w_hs, ar_hs;
    logic commit;
    logic [IDX_W-1:0]                          c_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0]             c_data;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]           c_strb;

    assign S_AXI_AWREADY = (w_state == W_IDLE) || (w_state == W_HAVE_W);
    assign S_AXI_WREADY  = (w_state == W_IDLE) || (w_state == W_HAVE_AW);
    assign S_AXI_BVALID  = (w_state == W_RESP);
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_ARREADY = (r_state == R_IDLE);
    assign S_AXI_RVALID  = (r_state == R_DATA);
    assign S_AXI_RRESP   = RESP_OKAY;
    assign reg_q         = regs;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // Pick whichever half of the write was latched earlier and the half arriving now.
    always_comb begin
        commit = 1'b0;
        c_idx  = S_AXI_AWADDR[ADDR_LSB +: IDX_W];
        c_data = S_AXI_WDATA;
        c_strb = S_AXI_WSTRB;
        case (w_state)
            W_IDLE:    commit = aw_hs && w_hs;
            W_HAVE_AW: begin
                commit = w_hs;
                c_idx  = aw_idx;
            end
            W_HAVE_W:  begin
                commit = aw_hs;
                c_data = wdata_q;
                c_strb = wstrb_q;
            end
            default:   commit = 1'b0;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            w_state <= W_IDLE;
            aw_idx  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            regs    <= '0;
            reg_wr  <= '0;
        end else begin
            reg_wr <= '0;
            if (commit) begin
                regs[c_idx]   <= apply_wstrb(regs[c_idx], c_data, c_strb);
                reg_wr[c_idx] <= |c_strb;
            end
            case (w_state)
                W_IDLE: begin
                    if (aw_hs && w_hs) begin
                        w_state <= W_RESP;
                    end else if (aw_hs) begin
                        aw_idx  <= S_AXI_AWADDR[ADDR_LSB +: IDX_W];
                        w_state <= W_HAVE_AW;
                    end else if (w_hs) begin
                        wdata_q <= S_AXI_WDATA;
                        wstrb_q <= S_AXI_WSTRB;
                        w_state <= W_HAVE_W;
                    end
                end
                W_HAVE_AW: if (w_hs) w_state <= W_RESP;
                W_HAVE_W:  if (aw_hs) w_state <= W_RESP;
                W_RESP:    if (S_AXI_BREADY) w_state <= W_IDLE;
                default:   w_state <= W_IDLE;
            endcase
        end
    end

    // regs is sampled before this edge's commit, so a colliding read sees the old value.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state     <= R_IDLE;
            S_AXI_RDATA <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (ar_hs) begin
                    S_AXI_RDATA <= regs[S_AXI_ARADDR[ADDR_LSB +: IDX_W]];
                    r_state     <= R_DATA;
                end
                R_DATA: if (S_AXI_RREADY) r_state <= R_IDLE;
                default: r_state <= R_IDLE;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

endmodule

// File: tb/tb_datapath_axil_regs.sv
// Directed bench for datapath_axil_regs: ordering, strobes, backpressure,
// read/write collision and mid-transaction reset.
module tb_datapath_axil_regs;

    logic         ACLK = 1'b0;
    logic         ARESETN;
    logic [3:0]   S_AXI_AWADDR;
    logic [2:0]   S_AXI_AWPROT;
    logic         S_AXI_AWVALID;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA;
    logic [3:0]   S_AXI_WSTRB;
    logic         S_AXI_WVALID;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY;
    logic [3:0]   S_AXI_ARADDR;
    logic [2:0]   S_AXI_ARPROT;
    logic         S_AXI_ARVALID;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY;
    logic [127:0] reg_q;
    logic [3:0]   reg_wr;

    int checks   = 0;
    int failures = 0;

    always #5 ACLK = ~ACLK;

    datapath_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .reg_q(reg_q), .reg_wr(reg_wr)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // All driving and sampling happens on the falling edge.
    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int cyc = 0;
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_BREADY = 1'b0;
        while (!(aw_done && w_done)) begin
            if (cyc >= 50) begin
                checks++; failures++;
                $display("FAIL write_handshake_timeout observed=%0d expected<50", cyc);
                break;
            end
            S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
            S_AXI_WVALID  = !w_done  && (cyc >= w_dly);
            if (w_done && !aw_done) check("wready_drop", S_AXI_WREADY, 0);
            if (aw_done && !w_done) check("awready_drop", S_AXI_AWREADY, 0);
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            @(negedge ACLK);
            aw_done |= aw_hs; w_done |= w_hs; cyc++;
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        check("bvalid_rise", S_AXI_BVALID, 1);
        check("bresp_okay", S_AXI_BRESP, 2'b00);
        if (s != 4'b0) check("reg_wr_pulse", reg_wr, 4'b0001 << a[3:2]);
        for (int i = 0; i < b_dly; i++) begin
            @(negedge ACLK);
            check("bvalid_hold", S_AXI_BVALID, 1);
            check("aw_w_ready_blocked", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b00);
        end
        S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0;
        check("bvalid_single", S_AXI_BVALID, 0);
        check("reg_wr_clear", reg_wr, 4'b0000);
    endtask

    task automatic axi_read(input logic [3:0] a, input logic [31:0] exp, input int r_dly);
        int cyc = 0;
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        while (!S_AXI_ARREADY && cyc < 50) begin
            @(negedge ACLK); cyc++;
        end
        if (cyc >= 50) begin
            checks++; failures++;
            $display("FAIL arready_timeout observed=%0d expected<50", cyc);
        end
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        check("rvalid_rise", S_AXI_RVALID, 1);
        check("rdata", S_AXI_RDATA, exp);
        check("rresp_okay", S_AXI_RRESP, 2'b00);
        for (int i = 0; i < r_dly; i++) begin
            @(negedge ACLK);
            check("rvalid_hold", S_AXI_RVALID, 1);
            check("rdata_hold", S_AXI_RDATA, exp);
            check("arready_blocked", S_AXI_ARREADY, 0);
        end
        S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_RREADY = 1'b0;
        check("rvalid_single", S_AXI_RVALID, 0);
    endtask

    initial begin
        ARESETN = 1'b0;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        repeat (20) @(negedge ACLK);
        ARESETN = 1'b1;

        check("rst_reg_q", reg_q, 128'h0);
        check("rst_reg_wr", reg_wr, 4'h0);
        check("rst_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
        check("rst_rdata", S_AXI_RDATA, 32'h0);
        check("rst_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

        // Basic writes and read-back.
        axi_write(4'h0, 32'h1, 4'hF, 0, 0, 0);
        axi_write(4'h4, 32'h2, 4'hF, 0, 0, 0);
        axi_write(4'h8, 32'h3, 4'hF, 0, 0, 0);
        axi_write(4'hC, 32'h4, 4'hF, 0, 0, 0);
        axi_read(4'h0, 32'h1, 0);
        axi_read(4'h5, 32'h2, 0);
        axi_read(4'h8, 32'h3, 0);
        axi_read(4'hF, 32'h4, 0);
        check("reg_q_all", reg_q, 128'h00000004_00000003_00000002_00000001);

        // Channel ordering: W three cycles ahead of AW, then AW ahead of W.
        axi_write(4'h8, 32'hDEADBEEF, 4'hF, 3, 0, 0);
        check("w_first_reg2", reg_q[95:64], 32'hDEADBEEF);
        axi_read(4'h8, 32'hDEADBEEF, 0);
        axi_write(4'h8, 32'h12345678, 4'hF, 0, 3, 0);
        check("aw_first_reg2", reg_q[95:64], 32'h12345678);

        // Byte strobes.
        axi_write(4'h4, 32'h11223344, 4'hF, 0, 0, 0);
        axi_write(4'h4, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
        check("strb_0101", reg_q[63:32], 32'h11BB33DD);
        axi_write(4'h4, 32'hFFFFFFFF, 4'b0000, 0, 0, 0);
        check("strb_0000", reg_q[63:32], 32'h11BB33DD);
        axi_read(4'h4, 32'h11BB33DD, 0);

        // Backpressure on both response channels.
        axi_write(4'hC, 32'hCAFEF00D, 4'hF, 0, 0, 10);
        axi_read(4'hC, 32'hCAFEF00D, 10);
        check("bp_reg3", reg_q[127:96], 32'hCAFEF00D);

        // Read accepted in the commit cycle of a write to the same register.
        axi_write(4'h4, 32'h22, 4'hF, 0, 0, 0);
        S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 4'h4; S_AXI_ARVALID = 1'b1;
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        check("coll_bvalid", S_AXI_BVALID, 1);
        check("coll_rvalid", S_AXI_RVALID, 1);
        check("coll_old_rdata", S_AXI_RDATA, 32'h22);
        check("coll_reg1_new", reg_q[63:32], 32'h55);
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
        check("coll_done", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
        axi_read(4'h4, 32'h55, 0);

        // Reset with only the address half of a write accepted.
        S_AXI_AWADDR = 4'h0; S_AXI_AWVALID = 1'b1;
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0;
        check("mid_awready_low", S_AXI_AWREADY, 0);
        ARESETN = 1'b0;
        @(negedge ACLK);
        ARESETN = 1'b1;
        check("mid_bvalid", S_AXI_BVALID, 0);
        check("mid_reg_q", reg_q, 128'h0);
        check("mid_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        @(negedge ACLK);
        check("mid_bvalid_later", S_AXI_BVALID, 0);
        axi_read(4'hC, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
